// File: rtl/ahb_wrr_burst_arbiter.sv
// Per-slave AHB arbiter: weighted round-robin at burst granularity with beat counting.
// Optional starvation timeout enabled by defining AHB_WRR_STARVE_TIMEOUT_EN.
module ahb_wrr_burst_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_W   = 4,
    parameter int TIMEOUT_W  = 6
) (
    input  logic                           hclk,
    input  logic                           hreset_n,
    input  logic [MASTER_NUM-1:0]          hreq,
    input  logic [2:0]                     hburst,
    input  logic                           hready,
    input  logic [MASTER_NUM*WEIGHT_W-1:0] weight,
    output logic [MASTER_NUM-1:0]          hgrant,
    output logic [$clog2(MASTER_NUM)-1:0]  hmaster,
    output logic                           hsel,
    output logic                           hlast
);
    localparam int IW = $clog2(MASTER_NUM);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state;
    logic [IW-1:0]       rr;
    logic [3:0]          count;
    logic [3:0]          lenm1_q;
    logic                incr_q;
    logic [WEIGHT_W-1:0] credit;

    logic [3:0]            lenm1;
    logic                  incr;
    logic                  last_beat;
    logic [MASTER_NUM-1:0] others;
    logic [WEIGHT_W-1:0]   new_credit;
    logic                  keep;
    logic                  switch_own;
    logic [IW-1:0]         pick_idle;
    logic [IW-1:0]         pick_sw;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
        return (v == IW'(MASTER_NUM - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MASTER_NUM-1:0] onehot(input logic [IW-1:0] v);
        logic [MASTER_NUM-1:0] r;
        r = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    function automatic logic [WEIGHT_W-1:0] weight_of(input logic [IW-1:0] v);
        logic [WEIGHT_W-1:0] w;
        w = weight[int'(v)*WEIGHT_W +: WEIGHT_W];
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    function automatic logic [IW-1:0] rr_pick(input logic [MASTER_NUM-1:0] req,
                                              input logic [IW-1:0] start);
        logic [IW-1:0] idx;
        logic [IW-1:0] win;
        logic          found;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = inc(idx);
        end
        return win;
    endfunction

    // Burst length is taken live from hburst until the first beat completes, then held.
    always_comb begin
        lenm1 = lenm1_q;
        incr  = incr_q;
        if (count == 4'd0) begin
            incr = 1'b0;
            case (hburst)
                3'd0:       lenm1 = 4'd0;
                3'd1:       begin lenm1 = 4'd15; incr = 1'b1; end
                3'd2, 3'd3: lenm1 = 4'd3;
                3'd4, 3'd5: lenm1 = 4'd7;
                default:    lenm1 = 4'd15;
            endcase
        end
    end

`ifdef AHB_WRR_STARVE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;
    logic                 tsat;
    assign tsat = &tcnt;
`endif

    always_comb begin
        last_beat  = (state == OWN) && hready &&
                     ((count == lenm1) || (incr && !hreq[hmaster]));
        others     = hreq & ~onehot(hmaster);
        new_credit = (credit == '0) ? '0 : credit - 1'b1;
`ifdef AHB_WRR_STARVE_TIMEOUT_EN
        if (tsat) new_credit = '0;
`endif
        keep       = hreq[hmaster] && (new_credit != '0);
        switch_own = last_beat && !keep && (|others);
        pick_idle  = rr_pick(hreq, rr);
        pick_sw    = rr_pick(others, inc(hmaster));
    end

    assign hsel  = |hgrant;
    assign hlast = last_beat;

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state   <= IDLE;
            hgrant  <= '0;
            hmaster <= '0;
            rr      <= '0;
            count   <= '0;
            lenm1_q <= '0;
            incr_q  <= 1'b0;
            credit  <= '0;
`ifdef AHB_WRR_STARVE_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|hreq) begin
                        state   <= OWN;
                        hgrant  <= onehot(pick_idle);
                        hmaster <= pick_idle;
                        count   <= '0;
                        credit  <= weight_of(pick_idle);
                    end
                end
                OWN: begin
                    if (count == 4'd0) begin
                        lenm1_q <= lenm1;
                        incr_q  <= incr;
                    end
                    if (hready) begin
                        if (!last_beat) begin
                            count <= count + 4'd1;
                        end else begin
                            count <= '0;
                            if (keep) begin
                                credit <= new_credit;
                            end else if (|others) begin
                                hgrant  <= onehot(pick_sw);
                                hmaster <= pick_sw;
                                credit  <= weight_of(pick_sw);
                                rr      <= inc(pick_sw);
                            end else if (hreq[hmaster]) begin
                                credit <= weight_of(hmaster);
                            end else begin
                                state   <= IDLE;
                                hgrant  <= '0;
                                hmaster <= '0;
                                credit  <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AHB_WRR_STARVE_TIMEOUT_EN
            // Counts cycles a non-owner waits; saturates so the pending preemption sticks.
            if (state != OWN || switch_own)
                tcnt <= '0;
            else if ((|others) && !tsat)
                tcnt <= tcnt + 1'b1;
`endif
        end
    end
endmodule
